// File: rtl/etapa_if_param.sv
// Instruction fetch stage with the IF/ID pipeline register.
// A small FSM covers start-up, normal fetch and the halted state after OP_ALTO.
module etapa_if_param #(
    parameter int                    ANCHO_INST = 14,
    parameter int                    ANCHO_OP   = 4,
    parameter int                    ANCHO_PC   = 8,
    parameter int                    PC_RESET   = 0,
    parameter logic [ANCHO_OP-1:0]   OP_ALTO    = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  salto,
    input  logic [ANCHO_PC-1:0]   dir_salto,
    input  logic [ANCHO_INST-1:0] imem_dato,
    output logic [ANCHO_PC-1:0]   imem_dir,
    output logic [ANCHO_INST-1:0] instruccion,
    output logic [ANCHO_OP-1:0]   opcode,
    output logic [ANCHO_PC-1:0]   pc_out,
    output logic                  valido,
    output logic [1:0]            estado
);

    typedef enum logic [1:0] {
        ARRANQUE = 2'b00,
        CAPTURA  = 2'b01,
        DETENIDO = 2'b10
    } estado_t;

    estado_t               estado_q, estado_d;
    logic [ANCHO_PC-1:0]   pc_q, pc_d;
    logic [ANCHO_INST-1:0] inst_q, inst_d;
    logic [ANCHO_OP-1:0]   op_q, op_d;
    logic [ANCHO_PC-1:0]   pc_out_q, pc_out_d;
    logic                  valido_q, valido_d;
    logic [ANCHO_OP-1:0]   op_fetch;

    assign op_fetch = imem_dato[ANCHO_INST-1 -: ANCHO_OP];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= ARRANQUE;
            pc_q     <= ANCHO_PC'(PC_RESET);
            inst_q   <= '0;
            op_q     <= '0;
            pc_out_q <= '0;
            valido_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            op_q     <= op_d;
            pc_out_q <= pc_out_d;
            valido_q <= valido_d;
        end
    end

    // A redirect always wins over stall so a flushed fetch can never turn valid.
    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        op_d     = op_q;
        pc_out_d = pc_out_q;
        valido_d = valido_q;
        case (estado_q)
            CAPTURA: begin
                if (salto) begin
                    pc_d     = dir_salto;
                    valido_d = 1'b0;
                end else if (!stall) begin
                    inst_d   = imem_dato;
                    op_d     = op_fetch;
                    pc_out_d = pc_q;
                    valido_d = 1'b1;
                    if (op_fetch == OP_ALTO) begin
                        estado_d = DETENIDO;
                    end else begin
                        pc_d = pc_q + ANCHO_PC'(1);
                    end
                end
            end
            DETENIDO: begin
                valido_d = 1'b0;
                if (salto) begin
                    pc_d     = dir_salto;
                    estado_d = CAPTURA;
                end
            end
            default: begin
                // Unused code 11 recovers exactly like ARRANQUE.
                valido_d = 1'b0;
                estado_d = CAPTURA;
                if (salto) begin
                    pc_d = dir_salto;
                end
            end
        endcase
    end

    assign imem_dir    = pc_q;
    assign instruccion = inst_q;
    assign opcode      = op_q;
    assign pc_out      = pc_out_q;
    assign valido      = valido_q;
    assign estado      = estado_q;

endmodule

// File: tb/tb_etapa_if_param.sv
// Directed bench for etapa_if_param: a combinational memory model feeds the
// fetch stage and every expected value below is worked out by hand.
module tb_etapa_if_param;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        salto;
    logic [7:0]  dir_salto;
    logic [13:0] imem_dato;
    logic [7:0]  imem_dir;
    logic [13:0] instruccion;
    logic [3:0]  opcode;
    logic [7:0]  pc_out;
    logic        valido;
    logic [1:0]  estado;

    logic [13:0] mem [256];
    int          error_count = 0;
    int          check_count = 0;

    etapa_if_param dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .salto       (salto),
        .dir_salto   (dir_salto),
        .imem_dato   (imem_dato),
        .imem_dir    (imem_dir),
        .instruccion (instruccion),
        .opcode      (opcode),
        .pc_out      (pc_out),
        .valido      (valido),
        .estado      (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb imem_dato = mem[imem_dir];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic r, input logic st, input logic sa, input logic [7:0] dir);
        rst_n     = r;
        stall     = st;
        salto     = sa;
        dir_salto = dir;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int n = 0; n < 256; n++) mem[n] = 14'h0100 + 14'(n);
        mem[7]    = 14'h3C00;
        mem[8'h11] = 14'h3C11;
        rst_n = 1'b0; stall = 1'b0; salto = 1'b0; dir_salto = 8'h00;

        // Reset state
        applyStimulus(0, 1, 1, 8'h55);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("rst_estado", 32'(estado), 0);
        checkOutput("rst_valido", 32'(valido), 0);
        checkOutput("rst_imem_dir", 32'(imem_dir), 0);
        checkOutput("rst_instr", 32'(instruccion), 0);
        checkOutput("rst_pc_out", 32'(pc_out), 0);
        checkOutput("rst_opcode", 32'(opcode), 0);

        // ARRANQUE lasts one cycle, stall ignored
        applyStimulus(1, 1, 0, 8'h00);
        checkOutput("arr_estado", 32'(estado), 1);
        checkOutput("arr_valido", 32'(valido), 0);
        checkOutput("arr_imem_dir", 32'(imem_dir), 0);

        // Sequential fetch
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("seq0_valido", 32'(valido), 1);
        checkOutput("seq0_pc_out", 32'(pc_out), 0);
        checkOutput("seq0_instr", 32'(instruccion), 14'h0100);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 0, 0, 8'h00);
            checkOutput("seq_pc_out", 32'(pc_out), 32'(i));
            checkOutput("seq_instr", 32'(instruccion), 32'(14'h0100 + i));
        end

        // Stall holds for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 8'h00);
            checkOutput("stall_pc_out", 32'(pc_out), 5);
            checkOutput("stall_instr", 32'(instruccion), 14'h0105);
            checkOutput("stall_valido", 32'(valido), 1);
            checkOutput("stall_imem_dir", 32'(imem_dir), 6);
        end
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("unstall_pc_out", 32'(pc_out), 6);

        // Halt word at 7
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("halt_pc_out", 32'(pc_out), 7);
        checkOutput("halt_opcode", 32'(opcode), 4'hF);
        checkOutput("halt_valido", 32'(valido), 1);
        checkOutput("halt_imem_dir", 32'(imem_dir), 7);
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("det_estado", 32'(estado), 2);
        checkOutput("det_valido", 32'(valido), 0);
        checkOutput("det_imem_dir", 32'(imem_dir), 7);
        applyStimulus(1, 1, 0, 8'h00);
        checkOutput("det_stall_valido", 32'(valido), 0);
        checkOutput("det_stall_pc_out", 32'(pc_out), 7);
        applyStimulus(1, 0, 1, 8'h10);
        checkOutput("det_salto_estado", 32'(estado), 1);
        checkOutput("det_salto_valido", 32'(valido), 0);
        checkOutput("det_salto_imem_dir", 32'(imem_dir), 8'h10);
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("post_salto_pc_out", 32'(pc_out), 8'h10);
        checkOutput("post_salto_valido", 32'(valido), 1);

        // Halt word at 0x11 under stall is not taken until release
        applyStimulus(1, 1, 0, 8'h00);
        applyStimulus(1, 1, 0, 8'h00);
        checkOutput("halt_stall_estado", 32'(estado), 1);
        checkOutput("halt_stall_pc_out", 32'(pc_out), 8'h10);
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("halt_rel_pc_out", 32'(pc_out), 8'h11);
        checkOutput("halt_rel_estado", 32'(estado), 2);
        checkOutput("halt_rel_instr", 32'(instruccion), 14'h3C11);
        applyStimulus(1, 0, 0, 8'h00);

        // Reset while halted
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("det_rst_estado", 32'(estado), 0);
        checkOutput("det_rst_valido", 32'(valido), 0);
        checkOutput("det_rst_imem_dir", 32'(imem_dir), 0);
        checkOutput("det_rst_instr", 32'(instruccion), 0);

        // Redirect wins over stall and flushes
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("pre_jump_pc_out", 32'(pc_out), 0);
        applyStimulus(1, 1, 1, 8'h40);
        checkOutput("jump_valido", 32'(valido), 0);
        checkOutput("jump_imem_dir", 32'(imem_dir), 8'h40);
        checkOutput("jump_pc_out_held", 32'(pc_out), 0);
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("jump_pc_out", 32'(pc_out), 8'h40);
        checkOutput("jump_valido2", 32'(valido), 1);
        checkOutput("jump_instr", 32'(instruccion), 14'h0140);

        // PC wrap at 0xFF
        applyStimulus(1, 0, 1, 8'hFF);
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("wrap_pc_out", 32'(pc_out), 8'hFF);
        checkOutput("wrap_imem_dir", 32'(imem_dir), 8'h00);
        checkOutput("wrap_instr", 32'(instruccion), 14'h01FF);
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("wrap_pc_out2", 32'(pc_out), 8'h00);

        // Redirect during ARRANQUE
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(1, 0, 1, 8'h20);
        checkOutput("arr_salto_estado", 32'(estado), 1);
        checkOutput("arr_salto_imem_dir", 32'(imem_dir), 8'h20);
        checkOutput("arr_salto_valido", 32'(valido), 0);
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("arr_salto_pc_out", 32'(pc_out), 8'h20);
        checkOutput("arr_salto_valido2", 32'(valido), 1);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
